// File: rtl/seg7_scan_driver_if.sv
// Load handshake and display outputs of seg7_scan_driver.
// master = the side offering loads and watching the display; slave = the driver.
interface seg7_scan_driver_if;
  logic        load_valid;
  logic        load_ready;
  logic [39:0] symbols;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [7:0]  digit;
  logic        frame_done;

  modport master (
    output load_valid, symbols, blink_mask,
    input  load_ready, an, digit, frame_done
  );

  modport slave (
    input  load_valid, symbols, blink_mask,
    output load_ready, an, digit, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment scanner with double-buffered symbol loads.
// Blink support is compiled in only when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input logic              clock,
  input logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [39:0]   pend;
  logic [39:0]   active;
  logic          pend_full;
  logic          tc;
  logic          frame_end;
  logic          accept;
  logic [4:0]    code;
  logic [7:0]    glyph;
  logic          blank;

  function automatic logic [7:0] decode(input logic [4:0] c);
    logic [7:0] g;
    case (c)
      5'h00: g = 8'hC0;
      5'h01: g = 8'hF9;
      5'h02: g = 8'hA4;
      5'h03: g = 8'hB0;
      5'h04: g = 8'h99;
      5'h05: g = 8'h92;
      5'h06: g = 8'h82;
      5'h07: g = 8'hF8;
      5'h08: g = 8'h80;
      5'h09: g = 8'h90;
      5'h0A: g = 8'h88;
      5'h0B: g = 8'h83;
      5'h0C: g = 8'hC6;
      5'h0D: g = 8'hA1;
      5'h0E: g = 8'h86;
      5'h0F: g = 8'h8E;
      5'h11: g = 8'hBF;
      5'h12: g = 8'h8C;
      5'h13: g = 8'hE1;
      5'h14: g = 8'hA7;
      default: g = 8'hFF;
    endcase
    // Decimal point is never lit.
    return g | 8'h80;
  endfunction

  always_comb begin
    tc        = (cnt == LAST);
    frame_end = tc && (idx == 3'd7);
    accept    = bus.load_valid && !pend_full;
    code      = active[int'(idx) * 5 +: 5];
    glyph     = decode(code);
  end

  assign bus.load_ready = !pend_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      idx            <= 3'd0;
      pend           <= '0;
      pend_full      <= 1'b0;
      active         <= {8{5'h10}};
      bus.an         <= 8'hFF;
      bus.digit      <= 8'hFF;
      bus.frame_done <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) begin
        idx <= idx + 3'd1;
      end
      bus.frame_done <= frame_end;
      bus.an         <= ~(8'b1 << idx);
      bus.digit      <= blank ? 8'hFF : glyph;
      // A load can only be taken while pending is empty, so a load landing on
      // a boundary cycle is committed one frame later.
      if (accept) begin
        pend      <= bus.symbols;
        pend_full <= 1'b1;
      end else if (frame_end && pend_full) begin
        active    <= pend;
        pend_full <= 1'b0;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam logic [7:0] BLAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] fcnt;
  logic       phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fcnt  <= 8'd0;
      phase <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == BLAST) begin
        fcnt  <= 8'd0;
        phase <= !phase;
      end else begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  assign blank = phase && bus.blink_mask[idx];
`else
  logic unused_blink;
  assign unused_blink = ^bus.blink_mask;
  assign blank        = 1'b0;
`endif

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each digit is driven (legal 2..2^20).
REQ-002 SHALL have parameter BLINK_FRAMES, default 125, meaning frames per blink phase (legal 1..255).
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_valid  input  1  new display contents offered.
REQ-006 SHALL have port load_ready  output  1  block can accept a load.
REQ-007 SHALL have port symbols  input  40  eight 5-bit symbol codes; symbol k = symbols[5k+4:5k], shown on display k.
REQ-008 SHALL have port blink_mask  input  8  bit k set = display k blinks.
REQ-009 SHALL have port an  output  8  display select, active-low, an[k] = display k.
REQ-010 SHALL have port digit  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when a scan frame completes.

Function
REQ-012 SHALL keep a scan counter 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index increments 0..7, wrapping 7->0.
REQ-013 SHALL register an and digit; both reflect the current index one cycle after the index changes; an has exactly one bit low, an = ~(8'b1 << index).
REQ-014 SHALL decode codes 0x0..0xF to hex glyphs: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
REQ-015 SHALL decode 0x10 blank FF, 0x11 dash BF, 0x12 P 8C, 0x13 J E1, 0x14 lowercase c A7; codes 0x15..0x1F decode to FF.
REQ-016 SHALL always drive dp (digit[7]) = 1.
REQ-017 SHALL accept a load when load_valid && load_ready at a rising edge, capturing symbols into a pending buffer and driving load_ready = 0 from the next cycle.
REQ-018 SHALL, at frame boundary (terminal count while index = 7), copy pending into the active buffer if pending is full, then set load_ready = 1 on the next cycle.
REQ-019 SHALL ignore load_valid while load_ready = 0; pending contents are not overwritten.
REQ-020 SHALL commit a load accepted in the same cycle as a frame boundary at the following frame boundary, not the current one.
REQ-021 SHALL pulse frame_done for exactly one cycle, on the cycle after each frame boundary; frame length is 8*SCAN_DIV cycles.
REQ-022 SHALL leave active contents unchanged at frame boundaries with no pending load.

Reset
REQ-023 SHALL, while reset = 0, force an = FF, digit = FF, frame_done = 0, load_ready = 1, index = 0, counter = 0, pending empty, all active symbols = 0x10, blink phase = 0.
REQ-024 SHALL, on the first rising edge after reset release, drive an = FE and digit = FF.
REQ-025 SHALL, on reset assertion mid-frame or with a load pending, discard the pending load and restart scanning from index 0.

Configuration
REQ-026 SHALL compile blink support only when macro SEG7_BLINK_EN is defined.
REQ-027 SHALL, with SEG7_BLINK_EN, count frames and toggle blink phase every BLINK_FRAMES frames; while phase = 1 and blink_mask[index] = 1, digit = FF with an still driven.
REQ-028 SHALL, without SEG7_BLINK_EN, keep port blink_mask, ignore it, and omit frame-count and phase logic.

Verification (SCAN_DIV = 4, BLINK_FRAMES = 2)
REQ-029 SHALL cover reset: hold reset = 0 -> an = FF, digit = FF, load_ready = 1; release -> next edge an = FE, digit = FF; an sequence FE,FD,...,7F each 4 cycles.
REQ-030 SHALL cover load: symbols codes 8,7,6,5,4,3,2,1 (k = 0..7) with one-cycle load_valid -> load_ready low until frame boundary; next frame shows an = FE digit = 80, an = 7F digit = F9; frame_done pulses every 32 cycles.
REQ-031 SHALL cover backpressure: second load with all 0x11 while load_ready = 0 -> ignored; first contents displayed, later frames unchanged.
REQ-032 SHALL cover decode edges: codes 0x12,0x13,0x14,0x1F -> digit 8C, E1, A7, FF on their slots.
REQ-033 SHALL cover reset mid-operation: reset = 0 with load pending at index 5 -> an = FF immediately; after release all slots FF, load_ready = 1.
REQ-034 SHALL cover blink (SEG7_BLINK_EN): blink_mask = 01, all codes 0x0 -> display 0 digit C0 for 2 frames, FF for 2 frames, repeating; other displays steady C0; without macro display 0 steady C0.
